// File: rtl/rtc_cfg_ctrl.sv
// Front-panel edit sequencer for RTC date/time fields: field select, up/down ticks with auto-repeat,
// and a req/ack commit to the RTC write engine. Optional inactivity abort: `RTC_CFG_TIMEOUT_EN.
module rtc_cfg_ctrl #(
  parameter int unsigned HOLD_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD = 25000000,
  parameter int unsigned TIMEOUT       = 1000000000,
  parameter int unsigned NUM_FIELDS    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_config,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       write_ack,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       config_active,
  output logic       write_req,
  output logic       cfg_abort
);

  typedef enum logic [1:0] {StIdle, StEdit, StCommit} state_e;
  typedef enum logic [1:0] {RpIdle, RpHold, RpRepeat} rpt_e;

  localparam logic [3:0] LastField = 4'(NUM_FIELDS);

  state_e      state_q, state_d;
  rpt_e        rpt_q, rpt_d;
  logic [31:0] rpt_cnt_q, rpt_cnt_d;
  logic [3:0]  field_q, field_d;
  logic        up_tick_q, up_tick_d;
  logic        dn_tick_q, dn_tick_d;
  logic        abort_q, abort_d;
  logic        cfg_q, left_q, right_q, up_q, down_q;

  logic cfg_rise, left_rise, right_rise, up_rise, down_rise;
  logic up_only, dn_only, qual, qual_dn, start;
  logic timeout_hit;

  assign cfg_rise   = btn_config & ~cfg_q;
  assign left_rise  = btn_left & ~left_q;
  assign right_rise = btn_right & ~right_q;
  assign up_rise    = btn_up & ~up_q;
  assign down_rise  = btn_down & ~down_q;

  assign up_only = btn_up & ~btn_down;
  assign dn_only = btn_down & ~btn_up;
  assign qual    = up_only | dn_only;
  assign qual_dn = dn_only;
  // A button becoming the only one held (its own rise, or the other released) starts a fresh hold.
  assign start   = (up_only & (up_rise | (up_q & down_q))) |
                   (dn_only & (down_rise | (up_q & down_q)));

`ifdef RTC_CFG_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        any_btn;

  assign any_btn     = btn_config | btn_left | btn_right | btn_up | btn_down;
  assign timeout_hit = (state_q == StEdit) && !any_btn && (idle_cnt_q == TIMEOUT - 1);

  always_comb begin
    idle_cnt_d = 32'd0;
    if (state_q == StEdit && !any_btn && !timeout_hit && !cfg_rise) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    rpt_d     = rpt_q;
    rpt_cnt_d = rpt_cnt_q;
    up_tick_d = 1'b0;
    dn_tick_d = 1'b0;
    abort_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rpt_d     = RpIdle;
        rpt_cnt_d = 32'd0;
        if (cfg_rise) begin
          state_d = StEdit;
          field_d = 4'd1;
        end
      end

      StEdit: begin
        if (cfg_rise) begin
          state_d   = StCommit;
          field_d   = 4'd0;
          rpt_d     = RpIdle;
          rpt_cnt_d = 32'd0;
        end else if (timeout_hit) begin
          state_d   = StIdle;
          field_d   = 4'd0;
          abort_d   = 1'b1;
          rpt_d     = RpIdle;
          rpt_cnt_d = 32'd0;
        end else begin
          if (qual) begin
            if (start) begin
              up_tick_d = ~qual_dn;
              dn_tick_d = qual_dn;
              rpt_d     = RpHold;
              rpt_cnt_d = 32'd0;
            end else if (rpt_q == RpHold && rpt_cnt_q == HOLD_DELAY - 1) begin
              up_tick_d = ~qual_dn;
              dn_tick_d = qual_dn;
              rpt_d     = RpRepeat;
              rpt_cnt_d = 32'd0;
            end else if (rpt_q == RpRepeat && rpt_cnt_q == REPEAT_PERIOD - 1) begin
              up_tick_d = ~qual_dn;
              dn_tick_d = qual_dn;
              rpt_cnt_d = 32'd0;
            end else if (rpt_q != RpIdle) begin
              rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
          end else begin
            rpt_d     = RpIdle;
            rpt_cnt_d = 32'd0;
          end

          // Navigation only while neither value button is held; simultaneous left+right cancels.
          if (!(btn_up || btn_down) && (left_rise ^ right_rise)) begin
            if (right_rise) begin
              field_d = (field_q == LastField) ? 4'd1 : field_q + 4'd1;
            end else begin
              field_d = (field_q == 4'd1) ? LastField : field_q - 4'd1;
            end
            rpt_d     = RpIdle;
            rpt_cnt_d = 32'd0;
          end
        end
      end

      StCommit: begin
        if (write_ack) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        field_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      field_q   <= 4'd0;
      rpt_q     <= RpIdle;
      rpt_cnt_q <= 32'd0;
      up_tick_q <= 1'b0;
      dn_tick_q <= 1'b0;
      abort_q   <= 1'b0;
      cfg_q     <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      rpt_q     <= rpt_d;
      rpt_cnt_q <= rpt_cnt_d;
      up_tick_q <= up_tick_d;
      dn_tick_q <= dn_tick_d;
      abort_q   <= abort_d;
      cfg_q     <= btn_config;
      left_q    <= btn_left;
      right_q   <= btn_right;
      up_q      <= btn_up;
      down_q    <= btn_down;
    end
  end

  assign en_count      = field_q;
  assign enUP          = up_tick_q;
  assign enDOWN        = dn_tick_q;
  assign config_active = (state_q != StIdle);
  assign write_req     = (state_q == StCommit);
  assign cfg_abort     = abort_q;

endmodule

// File: tb/tb_rtc_cfg_ctrl.sv
// Directed bench for rtc_cfg_ctrl with HOLD_DELAY=4, REPEAT_PERIOD=2, TIMEOUT=20.
module tb_rtc_cfg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_config, btn_left, btn_right, btn_up, btn_down, write_ack;
  logic [3:0] en_count;
  logic       enUP, enDOWN, config_active, write_req, cfg_abort;

  int checks = 0;
  int errors = 0;

  rtc_cfg_ctrl #(
    .HOLD_DELAY   (4),
    .REPEAT_PERIOD(2),
    .TIMEOUT      (20),
    .NUM_FIELDS   (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_config   (btn_config),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .write_ack    (write_ack),
    .en_count     (en_count),
    .enUP         (enUP),
    .enDOWN       (enDOWN),
    .config_active(config_active),
    .write_req    (write_req),
    .cfg_abort    (cfg_abort)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0 config, 1 left, 2 right
  task automatic pulse(input int b);
    case (b)
      0: btn_config = 1'b1;
      1: btn_left   = 1'b1;
      default: btn_right = 1'b1;
    endcase
    step();
    btn_config = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    step();
  endtask

  initial begin
    logic [16:0] mask;
    reset = 1'b1;
    btn_config = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; write_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_en_count", en_count, 0);
    chk("rst_active", config_active, 0);
    chk("rst_write_req", write_req, 0);
    chk("rst_ticks", {enUP, enDOWN}, 0);
    chk("rst_abort", cfg_abort, 0);

    // Field navigation
    btn_config = 1'b1;
    step();
    btn_config = 1'b0;
    chk("enter_en_count", en_count, 1);
    chk("enter_active", config_active, 1);
    step();
    for (int i = 0; i < 4; i++) pulse(2);
    chk("right4", en_count, 5);
    pulse(2);
    pulse(2);
    chk("right_wrap", en_count, 1);
    pulse(1);
    chk("left_wrap", en_count, 6);

    // Auto-repeat up: ticks at 1,5,7,9,11 after the edge, none after release at 12
    mask = 17'h00AA2;
    btn_up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 12) btn_up = 1'b0;
      chk($sformatf("up_tick_%0d", i), enUP, {31'd0, mask[i]});
      chk($sformatf("up_nodn_%0d", i), enDOWN, 0);
    end
    btn_down = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 12) btn_down = 1'b0;
      chk($sformatf("dn_tick_%0d", i), enDOWN, {31'd0, mask[i]});
      chk($sformatf("dn_noup_%0d", i), enUP, 0);
    end
    chk("field_kept", en_count, 6);

    // Both held: silent; releasing up restarts HOLD timing on down
    btn_up = 1'b1;
    btn_down = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("both_%0d", i), {enUP, enDOWN}, 0);
    end
    btn_up = 1'b0;
    mask = 17'h000A2;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk($sformatf("rel_dn_%0d", j), enDOWN, {31'd0, mask[j]});
      chk($sformatf("rel_noup_%0d", j), enUP, 0);
    end
    btn_down = 1'b0;
    step();

    // Simultaneous left+right cancels; navigation ignored while up held
    btn_left = 1'b1;
    btn_right = 1'b1;
    step();
    btn_left = 1'b0;
    btn_right = 1'b0;
    chk("lr_same_cycle", en_count, 6);
    btn_up = 1'b1;
    step();
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    chk("nav_while_up", en_count, 6);
    btn_up = 1'b0;
    step();
    step();

    // Commit with delayed ack
    btn_config = 1'b1;
    step();
    btn_config = 1'b0;
    chk("commit_req", write_req, 1);
    chk("commit_en", en_count, 0);
    chk("commit_active", config_active, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("commit_hold_%0d", i), write_req, 1);
    end
    write_ack = 1'b1;
    step();
    write_ack = 1'b0;
    chk("ack_req", write_req, 0);
    chk("ack_active", config_active, 0);

    // Config wins over right+up in EDIT; ack on first COMMIT cycle
    pulse(0);
    chk("reenter_en", en_count, 1);
    btn_config = 1'b1;
    btn_right = 1'b1;
    btn_up = 1'b1;
    step();
    btn_config = 1'b0;
    btn_right = 1'b0;
    btn_up = 1'b0;
    write_ack = 1'b1;
    chk("prio_req", write_req, 1);
    chk("prio_en", en_count, 0);
    chk("prio_notick", {enUP, enDOWN}, 0);
    step();
    write_ack = 1'b0;
    chk("ack_first_req", write_req, 0);
    chk("ack_first_active", config_active, 0);

    // Reset during COMMIT drops the request
    pulse(0);
    pulse(0);
    chk("pre_reset_req", write_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_req", write_req, 0);
    chk("midrst_active", config_active, 0);
    chk("midrst_en", en_count, 0);
    btn_up = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("idle_noup_%0d", i), enUP, 0);
    end
    btn_up = 1'b0;
    step();

    // Inactivity behaviour
    btn_config = 1'b1;
    step();
    btn_config = 1'b0;
`ifdef RTC_CFG_TIMEOUT_EN
    for (int i = 1; i <= 19; i++) begin
      step();
      chk($sformatf("to_wait_%0d", i), {config_active, cfg_abort, write_req}, 3'b100);
    end
    step();
    chk("to_abort", cfg_abort, 1);
    chk("to_active", config_active, 0);
    chk("to_en", en_count, 0);
    chk("to_req", write_req, 0);
    step();
    chk("to_abort_pulse", cfg_abort, 0);
`else
    for (int i = 0; i < 100; i++) step();
    chk("noto_active", config_active, 1);
    chk("noto_en", en_count, 1);
    chk("noto_abort", cfg_abort, 0);
    chk("noto_req", write_req, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
